// File: rtl/fib_rom_arbiter_if.sv
// Request/response bundle between the two ROM clients and fib_rom_arbiter.
// The master side is the client logic; the slave side is the arbiter.
interface fib_rom_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 24
);
  logic [1:0]        req;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [1:0]        gnt;
  logic [1:0]        rvalid;
  logic [DATA_W-1:0] rdata;
  logic              rerr;

  modport master (
    output req,
    output addr0,
    output addr1,
    input  gnt,
    input  rvalid,
    input  rdata,
    input  rerr
  );

  modport slave (
    input  req,
    input  addr0,
    input  addr1,
    output gnt,
    output rvalid,
    output rdata,
    output rerr
  );
endinterface

// File: rtl/fib_rom_arbiter.sv
// Round-robin share of the combinational Fibonacci ROM between two clients.
// One read per 3 cycles: arbitrate/grant, ROM read, response pulse.
module fib_rom_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 24,
  parameter int DEPTH  = 36
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fib_rom_arbiter_if.slave  bus,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_rom_rdadr,
  input  logic [DATA_W-1:0] i_rom_rddat
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_RESP
  } state_t;

  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);

  state_t            r_state;
  state_t            w_next;
  logic              r_win;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_gnt;
  logic [1:0]        r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rerr;

  logic              w_sel;
  logic              w_in_range;
  logic              w_win;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_gnt;
  logic [1:0]        w_rvalid;
  logic [DATA_W-1:0] w_rdata;
  logic              w_rerr;

  // On a tie the requester that did not win last time is served.
  assign w_sel = (&bus.req) ? ~r_last : bus.req[1];

  assign w_in_range = {1'b0, r_addr} < LIM;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_win    <= 1'b0;
      r_last   <= 1'b1;
      r_addr   <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_rerr   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_win    <= w_win;
      r_last   <= w_last;
      r_addr   <= w_addr;
      r_gnt    <= w_gnt;
      r_rvalid <= w_rvalid;
      r_rdata  <= w_rdata;
      r_rerr   <= w_rerr;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_win    = r_win;
    w_last   = r_last;
    w_addr   = r_addr;
    w_gnt    = '0;
    w_rvalid = '0;
    w_rdata  = r_rdata;
    w_rerr   = r_rerr;
    unique case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_win  = w_sel;
          w_addr = w_sel ? bus.addr1 : bus.addr0;
          w_gnt  = w_sel ? 2'b10 : 2'b01;
          w_next = S_READ;
        end
      end
      S_READ: begin
        w_rdata  = w_in_range ? i_rom_rddat : '0;
        w_rerr   = ~w_in_range;
        w_rvalid = r_win ? 2'b10 : 2'b01;
        w_next   = S_RESP;
      end
      S_RESP: begin
        w_last = r_win;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Out-of-range addresses never reach the ROM.
  assign o_rom_rdadr =
    (r_state == S_READ && w_in_range) ? r_addr : '0;

  assign o_busy     = (r_state != S_IDLE);
  assign bus.gnt    = r_gnt;
  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = r_rdata;
  assign bus.rerr   = r_rerr;

endmodule

// File: doc/fib_rom_arbiter.md
Name: fib_rom_arbiter

Overview:
Two-requester round-robin arbiter and read sequencer for the 36-entry, 24-bit Fibonacci lookup ROM. The ROM has a combinational read port; this block shares it between two clients, registers the read data, and flags out-of-range addresses. It sits between the ROM instance and the client logic, for example a display driver and a test sequencer.

Parameters:
ADDR_W, 24, width of request address and ROM read address
DATA_W, 24, width of ROM data and response data
DEPTH, 36, number of valid ROM entries; addresses >= DEPTH are out of range

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  2  per-requester request; bit i belongs to requester i
addr0  input  ADDR_W  requester 0 address, valid while req[0]=1
addr1  input  ADDR_W  requester 1 address, valid while req[1]=1
gnt  output  2  one-cycle grant pulse, one-hot
rvalid  output  2  one-cycle response-valid pulse, one-hot
rdata  output  DATA_W  shared response data, valid when any rvalid bit is set
rerr  output  1  out-of-range flag, valid with rvalid
busy  output  1  high whenever the FSM is not in IDLE
rom_rdadr  output  ADDR_W  drives the ROM rdadr input
rom_rddat  input  DATA_W  driven by the ROM rddat output

Behaviour:
- One clock; reset is synchronous and active-high on clk/rst.
- Reset values:
  - gnt=0, rvalid=0, rdata=0, rerr=0, busy=0, rom_rdadr=0.
  - FSM=IDLE, winner register=0, latched address=0.
  - last-winner pointer=1, so requester 0 wins the first tie.
- FSM states: IDLE, READ, RESP.
- IDLE, no req: stay in IDLE; all outputs stay at 0.
- IDLE, req!=0:
  - Select the winner:
    - single requester: that requester wins;
    - both requesting: the requester that is not the last winner wins.
  - Latch the winner id and its address.
  - gnt[winner]=1 for exactly one cycle (registered).
  - Go to READ.
- READ:
  - rom_rdadr = latched address if it is < DEPTH, else 0 (this never indexes outside the ROM).
  - At the end of the cycle, register rdata = rom_rddat and rerr=0 for an in-range address.
  - For an out-of-range address, register rdata=0 and rerr=1.
  - Go to RESP.
- RESP:
  - rvalid[winner]=1 for one cycle; rdata and rerr are stable during it.
  - Update last-winner pointer to the winner.
  - Go to IDLE.
- rdata and rerr hold their values after RESP until the next READ overwrites them.
- rom_rdadr returns to 0 outside READ.
- Latency, with req sampled at edge E0:
  - gnt high in cycle E0..E1;
  - rvalid high in cycle E1..E2;
  - next arbitration at edge E3.
  - Peak throughput is one read per 3 cycles.
- Handshake:
  - A requester holds req and its addr stable until it sees gnt, then may drop req or change addr.
  - req is ignored in READ and RESP.
  - A req that stays high after gnt is treated as a new request in the next IDLE.
- Address compare uses the full ADDR_W bits; no truncation.
- Simultaneous events:
  - Both requesting continuously → strict alternation 0,1,0,1...
  - One requester idle → the other is served back-to-back without waiting.
- Reset mid-operation (READ or RESP) → immediate return to the reset state; rvalid is not issued for the pending transaction. The requester must re-request.
- rst takes priority over all other activity in the same cycle.

Test Plan:
- Reset, then req=2'b01, addr0=10 → gnt=01 at E0+1, rvalid=01 at E1+1, rdata=55, rerr=0; busy high for exactly 2 cycles.
- req=2'b10, addr1=35 → rdata=9227465 (0x8CCCC9), rerr=0; addr1=0 → rdata=0; addr1=1 → rdata=1.
- addr0=36 and addr0=24'hFFFFFF → rom_rdadr stays 0, rvalid=01, rdata=0, rerr=1.
- req=2'b11 held for 12 cycles, addr0=5, addr1=6 → grants 01,10,01,10 every 3 cycles; responses 5, 8, 5, 8 on the matching rvalid bit.
- req=2'b01 held continuously → requester 0 is granted every 3 cycles with no idle gaps beyond the FSM; then req=2'b11 → requester 1 wins the next tie.
- Assert rst during READ → next cycle all outputs are 0, no rvalid pulse; a fresh req=2'b11 after reset grants requester 0 first.
